// File: rtl/inst_fetch.sv
// inst_fetch: instruction fetch stage.
// Issues one instruction memory request per PC value and presents the
// returned word to decode together with its address and address + 4.
// A skid register holds a word that returns while decode is stalled on
// the previous one. A flush drops everything, including a request still
// in flight.
// Optional feature: define IF_TIMEOUT_EN to abort a fetch after
// TIMEOUT_CYCLES cycles without an ack. The abort raises a sticky
// fetch_err, and the same address is then fetched again.

module inst_fetch #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] pc_in,
  output logic        pc_en,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        flush,
  output logic        if_valid,
  output logic [31:0] if_instr,
  output logic [31:0] if_pc,
  output logic [31:0] if_pc_plus4,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HOLD  = 2'd2
  } state_t;

  state_t      state;
  state_t      state_next;
  logic [31:0] req_addr;
  logic [31:0] skid_instr;
  logic [31:0] skid_pc;
  logic        drop;
  logic        timeout_hit;
  logic        load_fetch;
  logic        load_hold;
  logic        to_hold;

  assign imem_addr = req_addr;

`ifdef IF_TIMEOUT_EN
  logic [31:0] wait_cnt;
  logic        err_q;

  assign timeout_hit = (state == FETCH) && !imem_ack &&
                       (wait_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign fetch_err   = err_q;

  // Count consecutive unacknowledged fetch cycles; the error flag stays set until reset
  always_ff @(posedge clk) begin
    if (rst) begin
      wait_cnt <= '0;
      err_q    <= 1'b0;
    end else if (state == FETCH && !imem_ack) begin
      if (timeout_hit) begin
        wait_cnt <= '0;
        err_q    <= 1'b1;
      end else begin
        wait_cnt <= wait_cnt + 32'd1;
      end
    end else begin
      wait_cnt <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
  assign fetch_err   = 1'b0;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Next state, memory request, PC advance pulse and datapath load strobes.
  // A flush seen in IDLE keeps us there one more cycle so the redirected pc_in is latched.
  always_comb begin
    state_next = state;
    pc_en      = 1'b0;
    imem_req   = 1'b0;
    load_fetch = 1'b0;
    load_hold  = 1'b0;
    to_hold    = 1'b0;
    case (state)
      IDLE: begin
        if (!flush) state_next = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) begin
          if (flush || drop) begin
            state_next = IDLE;
          end else if (!if_valid || !stall) begin
            load_fetch = 1'b1;
            pc_en      = 1'b1;
            state_next = IDLE;
          end else begin
            to_hold    = 1'b1;
            state_next = HOLD;
          end
        end else if (timeout_hit) begin
          state_next = IDLE;
        end
      end
      HOLD: begin
        if (flush) begin
          state_next = IDLE;
        end else if (!stall) begin
          load_hold  = 1'b1;
          pc_en      = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
    if (rst) begin
      pc_en    = 1'b0;
      imem_req = 1'b0;
    end
  end

  // Request address, skid register, drop flag and the registered decode outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      req_addr    <= '0;
      skid_instr  <= '0;
      skid_pc     <= '0;
      drop        <= 1'b0;
      if_valid    <= 1'b0;
      if_instr    <= '0;
      if_pc       <= '0;
      if_pc_plus4 <= '0;
    end else begin
      if (state == IDLE) req_addr <= pc_in;

      if (flush) begin
        skid_instr <= '0;
        skid_pc    <= '0;
      end else if (to_hold) begin
        skid_instr <= imem_rdata;
        skid_pc    <= req_addr;
      end

      if (state == FETCH) begin
        if (imem_ack || timeout_hit) drop <= 1'b0;
        else if (flush)              drop <= 1'b1;
      end else begin
        drop <= 1'b0;
      end

      if (flush) begin
        if_valid <= 1'b0;
      end else if (load_fetch) begin
        if_valid    <= 1'b1;
        if_instr    <= imem_rdata;
        if_pc       <= req_addr;
        if_pc_plus4 <= req_addr + 32'd4;
      end else if (load_hold) begin
        if_valid    <= 1'b1;
        if_instr    <= skid_instr;
        if_pc       <= skid_pc;
        if_pc_plus4 <= skid_pc + 32'd4;
      end else if (if_valid && !stall) begin
        if_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inst_fetch.sv
// tb_inst_fetch: directed bench for inst_fetch with hand-computed expectations.
// Define IF_TIMEOUT_EN for both the bench and the RTL to exercise the timeout abort.

module tb_inst_fetch;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pc_in;
  logic        pc_en;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        flush;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] if_pc_plus4;
  logic        fetch_err;

  logic        auto_ack;
  logic        man_ack;
  int          check_cnt  = 0;
  int          passed_cnt = 0;
  int          pc_en_total = 0;
  int          pc_en_base;

  inst_fetch #(.TIMEOUT_CYCLES(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .pc_in      (pc_in),
    .pc_en      (pc_en),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .flush      (flush),
    .if_valid   (if_valid),
    .if_instr   (if_instr),
    .if_pc      (if_pc),
    .if_pc_plus4(if_pc_plus4),
    .fetch_err  (fetch_err)
  );

  // Clock
  always #5 clk = ~clk;

  // Zero-wait memory when auto_ack is set, otherwise a manually driven ack
  assign imem_ack = auto_ack ? imem_req : man_ack;

  // Count pc_en pulses mid-cycle
  always @(negedge clk) if (pc_en === 1'b1) pc_en_total <= pc_en_total + 1;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    check_cnt++;
    if (got !== exp) $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    else passed_cnt++;
  endtask

  task automatic applyStimulus(input logic [31:0] pc, input logic [31:0] word,
                               input logic st, input logic fl);
    pc_in      = pc;
    imem_rdata = word;
    stall      = st;
    flush      = fl;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst      = 1'b1;
    auto_ack = 1'b0;
    man_ack  = 1'b0;
    applyStimulus(32'h0, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Loads first word at 0x10, then returns second word for 0x14 while decode stalls
  task automatic enterHold(input logic [31:0] first, input logic [31:0] second);
    doReset();
    applyStimulus(32'h10, first, 1'b0, 1'b0);
    auto_ack = 1'b1;
    tick();
    tick();
    applyStimulus(32'h14, second, 1'b1, 1'b0);
    tick();
    checkOutput("stall_ack_no_pc_en", {31'd0, pc_en}, 32'd0);
    tick();
    auto_ack = 1'b0;
  endtask

  // Watchdog
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    // Reset values and a zero-wait fetch from address 0
    doReset();
    checkOutput("rst_if_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("rst_if_instr", if_instr, 32'h0);
    checkOutput("rst_if_pc", if_pc, 32'h0);
    checkOutput("rst_if_pc_plus4", if_pc_plus4, 32'h0);
    checkOutput("rst_imem_addr", imem_addr, 32'h0);
    checkOutput("rst_imem_req", {31'd0, imem_req}, 32'd0);
    checkOutput("rst_pc_en", {31'd0, pc_en}, 32'd0);
    checkOutput("rst_fetch_err", {31'd0, fetch_err}, 32'd0);
    pc_en_base = pc_en_total;
    applyStimulus(32'h0, 32'h20080005, 1'b0, 1'b0);
    auto_ack = 1'b1;
    tick();
    checkOutput("t1_imem_req", {31'd0, imem_req}, 32'd1);
    checkOutput("t1_imem_addr", imem_addr, 32'h0);
    checkOutput("t1_pc_en", {31'd0, pc_en}, 32'd1);
    tick();
    auto_ack = 1'b0;
    checkOutput("t1_if_valid", {31'd0, if_valid}, 32'd1);
    checkOutput("t1_if_instr", if_instr, 32'h20080005);
    checkOutput("t1_if_pc", if_pc, 32'h0);
    checkOutput("t1_if_pc_plus4", if_pc_plus4, 32'h4);
    tick();
    checkOutput("t1_consumed", {31'd0, if_valid}, 32'd0);
    tick();
    checkOutput("t1_pc_en_count", 32'(pc_en_total - pc_en_base), 32'd1);

    // Ack during stall goes to the skid register, released when stall drops
    enterHold(32'h11110000, 32'hAAAA0001);
    checkOutput("t2_hold_req", {31'd0, imem_req}, 32'd0);
    checkOutput("t2_hold_valid", {31'd0, if_valid}, 32'd1);
    checkOutput("t2_hold_instr", if_instr, 32'h11110000);
    checkOutput("t2_hold_pc", if_pc, 32'h10);
    tick();
    checkOutput("t2_hold_instr2", if_instr, 32'h11110000);
    pc_en_base = pc_en_total;
    stall = 1'b0;
    #1;
    checkOutput("t2_release_pc_en", {31'd0, pc_en}, 32'd1);
    tick();
    checkOutput("t2_instr", if_instr, 32'hAAAA0001);
    checkOutput("t2_pc", if_pc, 32'h14);
    checkOutput("t2_pc_plus4", if_pc_plus4, 32'h18);
    checkOutput("t2_valid", {31'd0, if_valid}, 32'd1);
    tick();
    checkOutput("t2_pc_en_count", 32'(pc_en_total - pc_en_base), 32'd1);

    // Ack delayed by three cycles: request and address stay stable
    doReset();
    pc_en_base = pc_en_total;
    applyStimulus(32'h40, 32'h12345678, 1'b0, 1'b0);
    tick();
    pc_in = 32'h44;
    for (int i = 0; i < 4; i++) begin
      man_ack = (i == 3);
      #1;
      checkOutput($sformatf("t3_req_c%0d", i), {31'd0, imem_req}, 32'd1);
      checkOutput($sformatf("t3_addr_c%0d", i), imem_addr, 32'h40);
      checkOutput($sformatf("t3_pc_en_c%0d", i), {31'd0, pc_en}, (i == 3) ? 32'd1 : 32'd0);
      tick();
    end
    man_ack = 1'b0;
    checkOutput("t3_valid", {31'd0, if_valid}, 32'd1);
    checkOutput("t3_instr", if_instr, 32'h12345678);
    checkOutput("t3_pc", if_pc, 32'h40);
    tick();
    tick();
    checkOutput("t3_pc_en_count", 32'(pc_en_total - pc_en_base), 32'd1);

    // Flush one cycle before a delayed ack drops the word
    doReset();
    pc_en_base = pc_en_total;
    applyStimulus(32'h80, 32'h0, 1'b0, 1'b0);
    tick();
    tick();
    flush = 1'b1;
    #1;
    checkOutput("t4_flush_pc_en", {31'd0, pc_en}, 32'd0);
    tick();
    applyStimulus(32'h100, 32'hDEAD0000, 1'b0, 1'b0);
    man_ack = 1'b1;
    #1;
    checkOutput("t4_ack_pc_en", {31'd0, pc_en}, 32'd0);
    checkOutput("t4_ack_req", {31'd0, imem_req}, 32'd1);
    checkOutput("t4_ack_addr", imem_addr, 32'h80);
    tick();
    man_ack = 1'b0;
    checkOutput("t4_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("t4_idle_req", {31'd0, imem_req}, 32'd0);
    tick();
    checkOutput("t4_new_addr", imem_addr, 32'h100);
    checkOutput("t4_new_req", {31'd0, imem_req}, 32'd1);
    checkOutput("t4_pc_en_count", 32'(pc_en_total - pc_en_base), 32'd0);

    // PC + 4 wraps at the top of the address space
    doReset();
    applyStimulus(32'hFFFFFFFC, 32'h00000013, 1'b0, 1'b0);
    auto_ack = 1'b1;
    tick();
    tick();
    auto_ack = 1'b0;
    checkOutput("t5_pc", if_pc, 32'hFFFFFFFC);
    checkOutput("t5_pc_plus4", if_pc_plus4, 32'h00000000);

    // Flush together with stall in HOLD: flush wins
    enterHold(32'h0A0A0A0A, 32'h0B0B0B0B);
    flush = 1'b1;
    #1;
    checkOutput("t6_pc_en", {31'd0, pc_en}, 32'd0);
    tick();
    flush = 1'b0;
    checkOutput("t6_valid", {31'd0, if_valid}, 32'd0);
    checkOutput("t6_idle_req", {31'd0, imem_req}, 32'd0);
    stall = 1'b0;
    tick();
    checkOutput("t6_refetch_req", {31'd0, imem_req}, 32'd1);
    checkOutput("t6_refetch_addr", imem_addr, 32'h14);

    // Reset mid-fetch, then a late ack is ignored
    doReset();
    applyStimulus(32'h200, 32'hBAD0BAD0, 1'b0, 1'b0);
    tick();
    checkOutput("t7_req", {31'd0, imem_req}, 32'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    man_ack = 1'b1;
    #1;
    checkOutput("t7_late_pc_en", {31'd0, pc_en}, 32'd0);
    checkOutput("t7_late_req", {31'd0, imem_req}, 32'd0);
    tick();
    man_ack = 1'b0;
    checkOutput("t7_valid", {31'd0, if_valid}, 32'd0);

    // Memory never acks
    doReset();
    applyStimulus(32'h300, 32'h0, 1'b0, 1'b0);
    tick();
`ifdef IF_TIMEOUT_EN
    repeat (15) tick();
    checkOutput("t8_err_before", {31'd0, fetch_err}, 32'd0);
    checkOutput("t8_req_before", {31'd0, imem_req}, 32'd1);
    tick();
    checkOutput("t8_err", {31'd0, fetch_err}, 32'd1);
    checkOutput("t8_req_dropped", {31'd0, imem_req}, 32'd0);
    tick();
    checkOutput("t8_refetch_req", {31'd0, imem_req}, 32'd1);
    checkOutput("t8_refetch_addr", imem_addr, 32'h300);
    checkOutput("t8_err_sticky", {31'd0, fetch_err}, 32'd1);
`else
    repeat (20) tick();
    checkOutput("t8_err", {31'd0, fetch_err}, 32'd0);
    checkOutput("t8_req", {31'd0, imem_req}, 32'd1);
    checkOutput("t8_addr", imem_addr, 32'h300);
`endif

    $display("%0d/%0d checks passed", passed_cnt, check_cnt);
    $finish;
  end

endmodule
